// File: rtl/game_pkg.sv
// Shared constants for the mole game: state encodings and count width.
// The LED feedback and display stages decode the same state values.
package game_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CD_W    = 3;

  // Encodings are fixed; downstream blocks decode these exact values.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'b000,
    ST_READY = 3'b001,
    ST_PLAY  = 3'b010,
    ST_OVER  = 3'b100
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sat_counter4.sv
// 4-bit up-counter with synchronous clear and saturation at 15.
// Ports: clk, rst (sync, active-high), clr (sync clear), inc (increment
// enable), count (registered value).
module sat_counter4
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; increment stops at CNT_MAX.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_scorekeeper.sv
// Game-level FSM and hit/miss tallies for the mole game.
// Ports: clk, rst (sync, active-high), start_btn (debounced level),
// tick_en (countdown pulse), hit, miss_evt (single-cycle pulses);
// outputs state, score, miss, win, countdown (all registered).
module game_scorekeeper
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 15,
  parameter int unsigned MAX_MISS    = 5,
  parameter int unsigned READY_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               tick_en,
  input  logic               hit,
  input  logic               miss_evt,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   score,
  output logic [CNT_W-1:0]   miss,
  output logic               win,
  output logic [CD_W-1:0]    countdown
);

  localparam logic [CNT_W-1:0] WIN_VAL  = CNT_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0] MISS_VAL = CNT_W'(MAX_MISS);
  localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(READY_TICKS);

  state_e            state_q;
  state_e            state_nxt;
  logic              win_nxt;
  logic [CD_W-1:0]   countdown_nxt;
  logic              start_d;
  logic              start_rise_c;
  logic              clr_c;
  logic              score_inc_c;
  logic              miss_inc_c;
  logic [CNT_W-1:0]  score_sat_c;
  logic [CNT_W-1:0]  miss_sat_c;

  assign state = state_q;

  // start_d resets high so a button held through reset is not an event.
  assign start_rise_c = start_btn & ~start_d;

  // Values the counters will hold after this edge if PLAY counts the pulse.
  assign score_sat_c = (hit && (score != CNT_MAX)) ? score + CNT_W'(1) : score;
  assign miss_sat_c  = (miss_evt && (miss != CNT_MAX)) ? miss + CNT_W'(1) : miss;

  // State, win, countdown and edge-detector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      win       <= 1'b0;
      countdown <= '0;
      start_d   <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      win       <= win_nxt;
      countdown <= countdown_nxt;
      start_d   <= start_btn;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_nxt     = state_q;
    win_nxt       = win;
    countdown_nxt = countdown;
    clr_c         = 1'b0;
    score_inc_c   = 1'b0;
    miss_inc_c    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise_c) begin
          state_nxt     = ST_READY;
          clr_c         = 1'b1;
          win_nxt       = 1'b0;
          countdown_nxt = CD_INIT;
        end
      end
      ST_READY: begin
        if (tick_en) begin
          // Treat 0 like 1 so a corrupted countdown cannot stall in READY.
          if (countdown <= CD_W'(1)) begin
            countdown_nxt = '0;
            state_nxt     = ST_PLAY;
          end else begin
            countdown_nxt = countdown - CD_W'(1);
          end
        end
      end
      ST_PLAY: begin
        score_inc_c = hit;
        miss_inc_c  = miss_evt;
        // Loss is checked first so it wins when both limits land together.
        if (miss_sat_c == MISS_VAL) begin
          state_nxt = ST_OVER;
          win_nxt   = 1'b0;
        end else if (score_sat_c == WIN_VAL) begin
          state_nxt = ST_OVER;
          win_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  sat_counter4 u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_c),
    .inc   (score_inc_c),
    .count (score)
  );

  sat_counter4 u_miss (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_c),
    .inc   (miss_inc_c),
    .count (miss)
  );

endmodule

// File: tb/tb_game_scorekeeper.sv
// Bench for game_scorekeeper: two instances (win at 15 and win at 4,
// both losing at 5 misses) share stimulus and are compared each cycle
// against a behavioural game model, plus directed spot checks.
module tb_game_scorekeeper;

  logic clk;
  logic rst;
  logic start_btn;
  logic tick_en;
  logic hit;
  logic miss_evt;

  logic [2:0] st_o [2];
  logic [3:0] sc_o [2];
  logic [3:0] ms_o [2];
  logic       wn_o [2];
  logic [2:0] cd_o [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Game model: phase 0=idle 1=ready 2=play 3=over.
  int win_lim [2] = '{15, 4};
  int miss_lim[2] = '{5, 5};
  int ph[2], sc[2], ms[2], wn[2], cd[2], sd[2];

  game_scorekeeper #(.WIN_SCORE(15), .MAX_MISS(5), .READY_TICKS(3)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .tick_en(tick_en),
    .hit(hit), .miss_evt(miss_evt), .state(st_o[0]), .score(sc_o[0]),
    .miss(ms_o[0]), .win(wn_o[0]), .countdown(cd_o[0])
  );

  game_scorekeeper #(.WIN_SCORE(4), .MAX_MISS(5), .READY_TICKS(3)) dut_lp (
    .clk(clk), .rst(rst), .start_btn(start_btn), .tick_en(tick_en),
    .hit(hit), .miss_evt(miss_evt), .state(st_o[1]), .score(sc_o[1]),
    .miss(ms_o[1]), .win(wn_o[1]), .countdown(cd_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int enc(input int p);
    case (p)
      1:       return 1;
      2:       return 2;
      3:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic new_game(input int k);
    ph[k] = 1; sc[k] = 0; ms[k] = 0; wn[k] = 0; cd[k] = 3;
  endtask

  task automatic model_update(input int k, input bit sb, input bit tk,
                              input bit h, input bit m, input bit r);
    bit rise;
    if (r) begin
      ph[k] = 0; sc[k] = 0; ms[k] = 0; wn[k] = 0; cd[k] = 0; sd[k] = 1;
      return;
    end
    rise = sb && (sd[k] == 0);
    if (ph[k] == 0 || ph[k] == 3) begin
      if (rise) new_game(k);
    end else if (ph[k] == 1) begin
      if (tk) begin
        cd[k] = cd[k] - 1;
        if (cd[k] == 0) ph[k] = 2;
      end
    end else begin
      sc[k] = sat15(sc[k] + int'(h));
      ms[k] = sat15(ms[k] + int'(m));
      if (ms[k] == miss_lim[k]) begin
        ph[k] = 3; wn[k] = 0;
      end else if (sc[k] == win_lim[k]) begin
        ph[k] = 3; wn[k] = 1;
      end
    end
    sd[k] = int'(sb);
  endtask

  // Apply one cycle of inputs, advance the model, compare both instances.
  task automatic step(input bit sb, input bit tk, input bit h, input bit m, input bit r);
    start_btn = sb; tick_en = tk; hit = h; miss_evt = m; rst = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k, sb, tk, h, m, r);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d_state", k), 32'(st_o[k]), 32'(enc(ph[k])));
      check($sformatf("u%0d_score", k), 32'(sc_o[k]), 32'(sc[k]));
      check($sformatf("u%0d_miss", k),  32'(ms_o[k]), 32'(ms[k]));
      check($sformatf("u%0d_win", k),   32'(wn_o[k]), 32'(wn[k]));
      check($sformatf("u%0d_cd", k),    32'(cd_o[k]), 32'(cd[k]));
    end
  endtask

  task automatic run_countdown();
    for (int t = 0; t < 3; t++) begin
      step(1, 1, 0, 0, 0);
      check("cd_tick", 32'(cd_o[0]), 32'(2 - t));
      if (t < 2) repeat (3) step(1, 0, 0, 0, 0);
    end
    check("cd_play", 32'(st_o[0]), 32'd2);
  endtask

  initial begin
    bit sb_lvl;
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; sc[k] = 0; ms[k] = 0; wn[k] = 0; cd[k] = 0; sd[k] = 1;
    end
    start_btn = 1'b1; tick_en = 1'b0; hit = 1'b0; miss_evt = 1'b0; rst = 1'b1;

    // Reset with button held: no start event afterwards.
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("rst_state", 32'(st_o[0]), 32'd0);
    repeat (5) step(1, 0, 0, 0, 0);
    check("held_btn_idle", 32'(st_o[0]), 32'd0);
    step(0, 0, 0, 0, 0);

    // Events ignored in IDLE.
    step(0, 0, 1, 1, 0);
    check("idle_ignore_score", 32'(sc_o[0]), 32'd0);

    // Start, then ignored events in READY, then countdown to PLAY.
    step(1, 0, 0, 0, 0);
    check("start_ready", 32'(st_o[0]), 32'd1);
    check("start_cd", 32'(cd_o[0]), 32'd3);
    step(1, 0, 1, 1, 0);
    check("ready_ignore_miss", 32'(ms_o[0]), 32'd0);
    run_countdown();

    // Start rise in PLAY does nothing.
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("play_start_ignored", 32'(st_o[0]), 32'd2);

    // Win path on the 15-point instance.
    for (int i = 1; i <= 15; i++) begin
      step(1, 0, 1, 0, 0);
      check("win_score", 32'(sc_o[0]), 32'(i));
      if (i == 15) begin
        check("win_over", 32'(st_o[0]), 32'd4);
        check("win_flag", 32'(wn_o[0]), 32'd1);
      end
      step(1, 0, 0, 0, 0);
    end
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0);
    check("over_hold_score", 32'(sc_o[0]), 32'd15);
    check("over_hold_miss", 32'(ms_o[0]), 32'd0);

    // Restart from OVER clears on the same edge.
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("restart_state", 32'(st_o[0]), 32'd1);
    check("restart_score", 32'(sc_o[0]), 32'd0);
    check("restart_win", 32'(wn_o[0]), 32'd0);
    run_countdown();

    // Loss priority on the win-at-4 instance: score 3, miss 4, then both.
    repeat (3) begin step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0); end
    repeat (4) begin step(1, 0, 0, 1, 0); step(1, 0, 0, 0, 0); end
    check("lp_pre_state", 32'(st_o[1]), 32'd2);
    step(1, 0, 1, 1, 0);
    check("lp_score", 32'(sc_o[1]), 32'd4);
    check("lp_miss", 32'(ms_o[1]), 32'd5);
    check("lp_state", 32'(st_o[1]), 32'd4);
    check("lp_win", 32'(wn_o[1]), 32'd0);

    // Mid-game reset.
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    run_countdown();
    repeat (7) begin step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0); end
    check("mid_score", 32'(sc_o[0]), 32'd7);
    step(1, 0, 0, 0, 1);
    check("mid_rst_state", 32'(st_o[0]), 32'd0);
    check("mid_rst_score", 32'(sc_o[0]), 32'd0);

    // Random play against the model.
    sb_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) sb_lvl = ~sb_lvl;
      step(sb_lvl, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
